// File: rtl/memory_layer_controller_pkg.sv
// Shared types and select encodings for the GAM memory-layer controller and datapath.
package GAM_package;

  typedef enum logic [3:0] {
    IDLE, CLS_CHK, SCAN_INIT, SCAN_RD, SCAN_ED, SCAN_CMP, FETCH_S1,
    FETCH_S2, TH_CMP, NEW_NODE, UPDATE, CONNECT, DONE
  } mlc_state_T;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } comparator_T;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } RD_WR_T;

  localparam logic [1:0] SEL1_UPCNT   = 2'd0;
  localparam logic [1:0] SEL1_MIN1    = 2'd1;
  localparam logic [1:0] SEL1_MIN2    = 2'd2;
  localparam logic [1:0] SEL1_NODECNT = 2'd3;

  localparam logic [1:0] SEL2_X       = 2'd1;
  localparam logic [1:0] SEL2_WS1NEW  = 2'd2;

  localparam logic [1:0] SEL3_TINIT   = 2'd1;
  localparam logic [1:0] SEL3_THNEW   = 2'd2;

  localparam logic [1:0] SEL4_MINIT   = 2'd1;
  localparam logic [1:0] SEL4_MINC    = 2'd2;

  localparam logic [1:0] SEL5_ZERO    = 2'd0;
  localparam logic [1:0] SEL5_UPCNT   = 2'd1;
  localparam logic [1:0] SEL5_THS1    = 2'd2;

  localparam logic [1:0] SEL6_NODECNT = 2'd0;
  localparam logic [1:0] SEL6_MIN1ED  = 2'd1;

  localparam logic [1:0] DMX_ED       = 2'd1;
  localparam logic [1:0] DMX_WS1      = 2'd2;
  localparam logic [1:0] DMX_WS2      = 2'd3;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ld_upcounter;
    logic       en_upcounter;
    logic       en_node_counter;
    logic       en_connection;
    logic       en_2min;
    logic       learning_done;
    logic       x_c;
    logic       c_c;
    logic       w_c;
    logic       t_c;
    logic       m_c;
    RD_WR_T     rd_wr;
    logic [1:0] mux1_sel;
    logic [1:0] mux2_sel;
    logic [1:0] mux3_sel;
    logic [1:0] mux4_sel;
    logic [1:0] mux5_sel;
    logic [1:0] mux6_sel;
    logic [1:0] demux_sel;
  } ctrl_T;

endpackage

// File: rtl/memory_layer_controller_decode.sv
// Combinational state -> datapath control word decoder (Moore outputs).
module memory_layer_ctrl_decode
  import GAM_package::*;
(
  input  mlc_state_T state,
  input  logic       guard_hit,
  input  logic       last_q,
  output ctrl_T      ctrl
);

  always_comb begin
    ctrl      = '0;
    ctrl.busy = (state != IDLE);
    case (state)
      CLS_CHK: begin
        ctrl.mux5_sel = SEL5_ZERO;
        ctrl.mux6_sel = SEL6_NODECNT;
      end
      SCAN_INIT: ctrl.ld_upcounter = 1'b1;
      SCAN_RD: begin
        ctrl.w_c       = 1'b1;
        ctrl.mux1_sel  = SEL1_UPCNT;
        ctrl.demux_sel = DMX_ED;
      end
      SCAN_ED: begin
        ctrl.en_2min      = 1'b1;
        ctrl.en_upcounter = 1'b1;
      end
      SCAN_CMP: begin
        ctrl.mux5_sel = SEL5_UPCNT;
        ctrl.mux6_sel = SEL6_NODECNT;
      end
      FETCH_S1: begin
        ctrl.w_c       = 1'b1;
        ctrl.t_c       = 1'b1;
        ctrl.m_c       = 1'b1;
        ctrl.mux1_sel  = SEL1_MIN1;
        ctrl.demux_sel = DMX_WS1;
      end
      FETCH_S2: begin
        ctrl.w_c       = 1'b1;
        ctrl.mux1_sel  = SEL1_MIN2;
        ctrl.demux_sel = DMX_WS2;
      end
      TH_CMP: begin
        ctrl.mux5_sel = SEL5_THS1;
        ctrl.mux6_sel = SEL6_MIN1ED;
      end
      NEW_NODE: begin
        // A full class leaves the cycle empty: no write, no count.
        if (!guard_hit) begin
          ctrl.x_c             = 1'b1;
          ctrl.c_c             = 1'b1;
          ctrl.w_c             = 1'b1;
          ctrl.t_c             = 1'b1;
          ctrl.m_c             = 1'b1;
          ctrl.rd_wr           = WRITE;
          ctrl.mux1_sel        = SEL1_NODECNT;
          ctrl.mux2_sel        = SEL2_X;
          ctrl.mux3_sel        = SEL3_TINIT;
          ctrl.mux4_sel        = SEL4_MINIT;
          ctrl.en_node_counter = 1'b1;
        end
      end
      UPDATE: begin
        ctrl.w_c      = 1'b1;
        ctrl.t_c      = 1'b1;
        ctrl.m_c      = 1'b1;
        ctrl.rd_wr    = WRITE;
        ctrl.mux1_sel = SEL1_MIN1;
        ctrl.mux2_sel = SEL2_WS1NEW;
        ctrl.mux3_sel = SEL3_THNEW;
        ctrl.mux4_sel = SEL4_MINC;
      end
      CONNECT: ctrl.en_connection = 1'b1;
      DONE: begin
        ctrl.done          = 1'b1;
        ctrl.learning_done = last_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_layer_controller.sv
// Sequencing FSM for one GAM learning step: class check, distance scan, winner fetch, insert or update.
// Optional full-class guard with sticky overflow when MEMORY_LAYER_CTRL_GUARD_EN is defined.
module memory_layer_controller
  import GAM_package::*;
#(
  parameter int MAX_NODES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        last_sample,
  input  comparator_T comparator_c,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        ld_upcounter,
  output logic        en_upcounter,
  output logic        en_node_counter,
  output logic        en_connection,
  output logic        en_2min,
  output logic        learning_done,
  output logic        X_c,
  output logic        C_c,
  output logic        W_c,
  output logic        T_c,
  output logic        M_c,
  output RD_WR_T      RD_WR_c,
  output logic [1:0]  mux1_sel,
  output logic [1:0]  mux2_sel,
  output logic [1:0]  mux3_sel,
  output logic [1:0]  mux4_sel,
  output logic [1:0]  mux5_sel,
  output logic [1:0]  mux6_sel,
  output logic [1:0]  demux_sel
);

  localparam int SCAN_W = $clog2(MAX_NODES + 1);

  mlc_state_T        state_q, state_d;
  logic [SCAN_W-1:0] scan_n_q, scan_n_d;
  logic              last_q, last_d;
  logic              guard_hit;
  logic              two_winners;
  ctrl_T             ctrl;

  assign two_winners = (scan_n_q >= SCAN_W'(2));

`ifdef MEMORY_LAYER_CTRL_GUARD_EN
  logic overflow_q, overflow_d;

  assign guard_hit  = (state_q == NEW_NODE) && (scan_n_q == SCAN_W'(MAX_NODES));
  assign overflow_d = overflow_q | guard_hit;
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end
`else
  assign guard_hit = 1'b0;
  assign overflow  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      scan_n_q <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      scan_n_q <= scan_n_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    scan_n_d = scan_n_q;
    last_d   = last_q;
    case (state_q)
      IDLE: if (start) begin
        last_d  = last_sample;
        state_d = CLS_CHK;
      end
      CLS_CHK:   state_d = (comparator_c == CMP_EQ) ? NEW_NODE : SCAN_INIT;
      SCAN_INIT: begin
        scan_n_d = '0;
        state_d  = SCAN_RD;
      end
      SCAN_RD:   state_d = SCAN_ED;
      SCAN_ED: begin
        scan_n_d = scan_n_q + SCAN_W'(1);
        state_d  = SCAN_CMP;
      end
      // CMP_GT here means the counter ran past the class size; stop scanning.
      SCAN_CMP:  state_d = (comparator_c == CMP_LT) ? SCAN_RD : FETCH_S1;
      FETCH_S1:  state_d = two_winners ? FETCH_S2 : TH_CMP;
      FETCH_S2:  state_d = TH_CMP;
      TH_CMP:    state_d = (comparator_c == CMP_LT) ? NEW_NODE : UPDATE;
      NEW_NODE:  state_d = DONE;
      UPDATE:    state_d = two_winners ? CONNECT : DONE;
      CONNECT:   state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  memory_layer_ctrl_decode u_decode (
    .state     (state_q),
    .guard_hit (guard_hit),
    .last_q    (last_q),
    .ctrl      (ctrl)
  );

  assign busy            = ctrl.busy;
  assign done            = ctrl.done;
  assign ld_upcounter    = ctrl.ld_upcounter;
  assign en_upcounter    = ctrl.en_upcounter;
  assign en_node_counter = ctrl.en_node_counter;
  assign en_connection   = ctrl.en_connection;
  assign en_2min         = ctrl.en_2min;
  assign learning_done   = ctrl.learning_done;
  assign X_c             = ctrl.x_c;
  assign C_c             = ctrl.c_c;
  assign W_c             = ctrl.w_c;
  assign T_c             = ctrl.t_c;
  assign M_c             = ctrl.m_c;
  assign RD_WR_c         = ctrl.rd_wr;
  assign mux1_sel        = ctrl.mux1_sel;
  assign mux2_sel        = ctrl.mux2_sel;
  assign mux3_sel        = ctrl.mux3_sel;
  assign mux4_sel        = ctrl.mux4_sel;
  assign mux5_sel        = ctrl.mux5_sel;
  assign mux6_sel        = ctrl.mux6_sel;
  assign demux_sel       = ctrl.demux_sel;

endmodule

// File: tb/tb_memory_layer_controller.sv
// Bench for memory_layer_controller: table of learning steps against a small datapath model, plus reset/start corner cases.
module tb_memory_layer_controller;
  import GAM_package::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        last_sample;
  comparator_T comparator_c;
  logic        busy, done, overflow;
  logic        ld_upcounter, en_upcounter, en_node_counter, en_connection, en_2min, learning_done;
  logic        X_c, C_c, W_c, T_c, M_c;
  RD_WR_T      RD_WR_c;
  logic [1:0]  mux1_sel, mux2_sel, mux3_sel, mux4_sel, mux5_sel, mux6_sel, demux_sel;

  int n_cmp = 0;
  int n_bad = 0;

  // Datapath model: node count of the class, up-counter, and threshold result.
  int          n_nodes = 0;
  int          upcnt   = 0;
  comparator_T th_res  = CMP_EQ;

  memory_layer_controller #(.MAX_NODES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_sample(last_sample),
    .comparator_c(comparator_c), .busy(busy), .done(done), .overflow(overflow),
    .ld_upcounter(ld_upcounter), .en_upcounter(en_upcounter),
    .en_node_counter(en_node_counter), .en_connection(en_connection),
    .en_2min(en_2min), .learning_done(learning_done),
    .X_c(X_c), .C_c(C_c), .W_c(W_c), .T_c(T_c), .M_c(M_c), .RD_WR_c(RD_WR_c),
    .mux1_sel(mux1_sel), .mux2_sel(mux2_sel), .mux3_sel(mux3_sel),
    .mux4_sel(mux4_sel), .mux5_sel(mux5_sel), .mux6_sel(mux6_sel),
    .demux_sel(demux_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_upcounter)      upcnt <= 0;
    else if (en_upcounter) upcnt <= upcnt + 1;
  end

  always_comb begin
    int a;
    int b;
    comparator_c = CMP_GT;
    a = (mux5_sel == SEL5_UPCNT) ? upcnt : 0;
    b = (mux6_sel == SEL6_NODECNT) ? n_nodes : 1000;
    if (mux5_sel == SEL5_THS1 && mux6_sel == SEL6_MIN1ED) comparator_c = th_res;
    else if (a < b)                                      comparator_c = CMP_LT;
    else if (a == b)                                     comparator_c = CMP_EQ;
  end

  wire [27:0] all_outs = {busy, done, overflow, ld_upcounter, en_upcounter, en_node_counter,
                          en_connection, en_2min, learning_done, X_c, C_c, W_c, T_c, M_c,
                          mux1_sel, mux2_sel, mux3_sel, mux4_sel, mux5_sel, mux6_sel, demux_sel};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    comparator_T th;
    bit          last;
    int          done_cyc;
    int          n_2min;
    int          n_conn;
    int          nn_cyc;
    int          n_upd;
    int          n_fs2;
    bit          ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    int k, dcyc, c2min, cconn, nncyc, cupd, cfs2, cbusy, cld;
    string tag;
    tag = $sformatf("v%0d", idx);
    dcyc = 0; c2min = 0; cconn = 0; nncyc = 0; cupd = 0; cfs2 = 0; cbusy = 0; cld = 0;
    @(negedge clk);
    n_nodes = v.n; th_res = v.th; last_sample = v.last; start = 1'b1;
    @(negedge clk);
    start = 1'b0; last_sample = 1'b0;
    for (k = 1; k <= 80; k++) begin
      if (busy) cbusy++;
      if (en_2min) c2min++;
      if (en_connection) cconn++;
      if (learning_done) cld++;
      if (RD_WR_c == WRITE && en_node_counter && X_c && C_c && W_c && T_c && M_c &&
          mux1_sel == SEL1_NODECNT && mux2_sel == SEL2_X && mux3_sel == SEL3_TINIT &&
          mux4_sel == SEL4_MINIT) nncyc = k;
      if (RD_WR_c == WRITE && !X_c && !C_c && W_c && T_c && M_c && !en_node_counter &&
          mux1_sel == SEL1_MIN1 && mux2_sel == SEL2_WS1NEW && mux3_sel == SEL3_THNEW &&
          mux4_sel == SEL4_MINC) cupd++;
      if (RD_WR_c == READ && W_c && demux_sel == DMX_WS2 && mux1_sel == SEL1_MIN2) cfs2++;
      if (done) begin
        dcyc = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_cycle"}, dcyc, v.done_cyc);
    check({tag, "_busy_cycles"}, cbusy, v.done_cyc);
    check({tag, "_en_2min"}, c2min, v.n_2min);
    check({tag, "_en_connection"}, cconn, v.n_conn);
    check({tag, "_new_node_cycle"}, nncyc, v.nn_cyc);
    check({tag, "_update"}, cupd, v.n_upd);
    check({tag, "_fetch_s2"}, cfs2, v.n_fs2);
    check({tag, "_learning_done"}, cld, int'(v.last));
    @(negedge clk);
    check({tag, "_idle_after"}, int'(busy), 0);
    check({tag, "_overflow"}, int'(overflow), int'(v.ovf));
    if (dcyc == 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    int k, dcyc;
    vecs[0] = '{0, CMP_EQ, 1'b0,  3, 0, 0,  2, 0, 0, 1'b0};
    vecs[1] = '{3, CMP_EQ, 1'b0, 17, 3, 1,  0, 1, 1, 1'b0};
    vecs[2] = '{1, CMP_LT, 1'b0,  9, 1, 0,  8, 0, 0, 1'b0};
    vecs[3] = '{1, CMP_GT, 1'b1,  9, 1, 0,  0, 1, 0, 1'b0};
    vecs[4] = '{3, CMP_LT, 1'b1, 16, 3, 0, 15, 0, 1, 1'b0};
`ifdef MEMORY_LAYER_CTRL_GUARD_EN
    vecs[5] = '{2, CMP_LT, 1'b1, 13, 2, 0,  0, 0, 1, 1'b1};
`else
    vecs[5] = '{2, CMP_LT, 1'b1, 13, 2, 0, 12, 0, 1, 1'b0};
`endif

    rst_n = 1'b0; start = 1'b1; last_sample = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'(all_outs), 0);
    check("reset_rd_wr", int'(RD_WR_c), int'(READ));
    @(negedge clk);
    check("reset_hold_busy", int'(busy), 0);
    rst_n = 1'b1; start = 1'b0; last_sample = 1'b0;
    @(negedge clk);
    check("idle_outputs", int'(all_outs), 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset in the second SCAN_RD (cycle 6) of an N=3 step.
    n_nodes = 3; th_res = CMP_EQ; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midscan_in_scan_rd", int'(demux_sel), int'(DMX_ED));
    rst_n = 1'b0;
    @(negedge clk);
    check("midscan_reset_outputs", int'(all_outs), 0);
    check("midscan_reset_rd_wr", int'(RD_WR_c), int'(READ));
    rst_n = 1'b1;
    run_vec(6, '{1, CMP_EQ, 1'b0, 9, 1, 0, 0, 1, 0, 1'b0});

    // start held through DONE is ignored there and accepted from IDLE next cycle.
    @(negedge clk);
    n_nodes = 0; th_res = CMP_EQ; start = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_done_at_3", int'(done), 1);
    @(negedge clk);
    check("hold_idle_at_4", int'(busy), 0);
    @(negedge clk);
    check("hold_busy_at_5", int'(busy), 1);
    start = 1'b0;
    dcyc = 0;
    for (k = 5; k <= 20; k++) begin
      if (done) begin
        dcyc = k;
        break;
      end
      @(negedge clk);
    end
    check("hold_second_done", dcyc, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_layer_controller.md
# memory_layer_controller

Sequencing FSM for the GAM memory-layer datapath. On each `start` it runs one learning step for the held sample `x` of class `c`: an empty-class check, a Euclidean-distance scan of every stored node of class `c`, and a two-winner fetch. It then either inserts a new node or updates winner s1 and connects s1–s2. It drives every control and select input of the datapath and consumes only the datapath's comparator result.

## Interface
- `MAX_NODES`, 64: per-class node capacity; width of the internal scan counter is `$clog2(MAX_NODES+1)`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin one learning step; `x`/`c` held stable by upstream until `done`.
- `last_sample` in 1: sampled with `start`; marks the final sample of the epoch.
- `comparator_c` in `comparator_T`: `CMP_LT`/`CMP_EQ`/`CMP_GT` meaning mux5 output `<`/`=`/`>` mux6 output.
- `busy` out 1: high from the cycle after `start` is accepted through the `DONE` cycle.
- `done` out 1: one-cycle pulse in `DONE`.
- `overflow` out 1: sticky; present only with the guard macro.
- `ld_upcounter`, `en_upcounter`, `en_node_counter`, `en_connection`, `en_2min`, `learning_done` out 1 each.
- `X_c`, `C_c`, `W_c`, `T_c`, `M_c` out 1 each: memory field enables.
- `RD_WR_c` out `RD_WR_T`: memory read/write.
- `mux1_sel` … `mux6_sel`, `demux_sel` out 2 each.

## Operation
- States: `IDLE`, `CLS_CHK`, `SCAN_INIT`, `SCAN_RD`, `SCAN_ED`, `SCAN_CMP`, `FETCH_S1`, `FETCH_S2`, `TH_CMP`, `NEW_NODE`, `UPDATE`, `CONNECT`, `DONE`.
- `IDLE`: on `start`, latch `last_sample` and go to `CLS_CHK`. `start` is ignored in every other state.
- `CLS_CHK`: mux6 = `SEL6_NODECNT`, mux5 = `SEL5_ZERO`.
  - `CMP_EQ` (class empty) → `NEW_NODE`.
  - Otherwise → `SCAN_INIT`.
- `SCAN_INIT`: `ld_upcounter`=1; clear `scan_n`; `en_2min`=0 clears the min finder. → `SCAN_RD`.
- `SCAN_RD`: read with `W_c`=1, mux1 = `SEL1_UPCNT`, `demux_sel` = `DMX_ED`. → `SCAN_ED`.
- `SCAN_ED`: `en_2min`=1, `en_upcounter`=1, `scan_n`++. → `SCAN_CMP`.
- `SCAN_CMP`: mux5 = `SEL5_UPCNT`, mux6 = `SEL6_NODECNT`.
  - `CMP_LT` → `SCAN_RD`.
  - Otherwise → `FETCH_S1`.
- `FETCH_S1`: read `W`/`T`/`M` at `SEL1_MIN1`, `demux_sel` = `DMX_WS1`.
  - → `FETCH_S2` if `scan_n` ≥ 2.
  - Otherwise → `TH_CMP`.
- `FETCH_S2`: read `W` at `SEL1_MIN2`, `demux_sel` = `DMX_WS2`. → `TH_CMP`.
- `TH_CMP`: mux5 = `SEL5_THS1`, mux6 = `SEL6_MIN1ED`.
  - `CMP_LT` (distance exceeds threshold) → `NEW_NODE`.
  - Otherwise → `UPDATE`.
- `NEW_NODE`: one write cycle, address `SEL1_NODECNT`.
  - `X_c`=`C_c`=`W_c`=`T_c`=`M_c`=1.
  - mux2 = `SEL2_X`, mux3 = `SEL3_TINIT`, mux4 = `SEL4_MINIT`.
  - `en_node_counter`=1.
  - → `DONE`.
- `UPDATE`: one write cycle at `SEL1_MIN1`.
  - `W_c`=`T_c`=`M_c`=1; mux2 = `SEL2_WS1NEW`, mux3 = `SEL3_THNEW`, mux4 = `SEL4_MINC`.
  - → `CONNECT` if `scan_n` ≥ 2.
  - Otherwise → `DONE`.
- `CONNECT`: `en_connection`=1. → `DONE`.
- `DONE`: `done`=1; `learning_done`=1 if the latched `last_sample` was set. → `IDLE`.
- All control outputs are Moore, decoded from the registered state. Any output not named for a state is 0 / `READ` / select 0.

## Timing
- Reset: `rst_n`=0 at an edge forces `IDLE`, clears `scan_n`, the latched `last_sample` and `overflow`. This includes reset mid-scan or mid-write.
- Values in reset and `IDLE`: all outputs 0, `RD_WR_c`=`READ`.
- Latency, with `start` sampled at cycle 0 and N = nodes in class `c`:
  - Empty class: `DONE` at cycle 3.
  - N=1 update: `DONE` at cycle 9.
  - N≥2 update: `DONE` at 3N+8.
  - N≥2 new node: `DONE` at 3N+7.
- Each scan iteration is 3 cycles. The comparator is sampled only in `CLS_CHK`, `SCAN_CMP` and `TH_CMP`. `CMP_GT` in `SCAN_CMP` is treated as end of scan.
- `start` asserted in the `DONE` cycle is ignored. It is accepted from `IDLE` on the next cycle.

## Configuration
- `MEMORY_LAYER_CTRL_GUARD_EN` defined:
  - In `NEW_NODE` entry, if `scan_n` == `MAX_NODES`, the write and `en_node_counter` are suppressed. The FSM passes straight to `DONE` and `overflow` sets (sticky until reset).
- Not defined: no check is made, and `overflow` is tied 0.

## Structure
- `GAM_package` holds:
  - `mlc_state_T` enum.
  - `comparator_T` (`CMP_LT`=0, `CMP_EQ`=1, `CMP_GT`=2).
  - `RD_WR_T`.
  - The `SEL1_*`…`SEL6_*` and `DMX_*` select constants.
- One sub-module: `memory_layer_ctrl_decode`, a combinational state → control-word decoder. The FSM, `scan_n` and the latches live in the top.

## Test plan
- Reset with `start`=1 → no transition; all outputs 0, `RD_WR_c`=`READ`.
- Empty class: `CLS_CHK` returns `CMP_EQ` → `NEW_NODE` at cycle 2 with all five field enables and `en_node_counter`=1; `done` at cycle 3.
- N=3, `TH_CMP` returns `CMP_EQ` → exactly 3 `en_2min` pulses, one `UPDATE`, one `en_connection`; `done` at cycle 17.
- N=1, `TH_CMP` returns `CMP_LT` → no `FETCH_S2`, no `CONNECT`; `NEW_NODE` at cycle 8, `done` at cycle 9.
- `rst_n`=0 during the second `SCAN_RD` → `IDLE` next cycle; a new `start` reruns from `CLS_CHK`.
- Guard built, `MAX_NODES`=2, N=2, `TH_CMP` returns `CMP_LT` → no write, `overflow`=1, `done` at cycle 13. `last_sample`=1 → `learning_done` coincides with `done`.
